// File: rtl/eth_frame_tx_pkg.sv
// Shared definitions for the Ethernet frame packetizer: header geometry, FSM states and TX beat payload.
package eth_frame_tx_pkg;

    localparam int unsigned HDR_LEN           = 14;
    localparam int unsigned HDR_BITS          = HDR_LEN * 8;
    localparam logic [15:0] DEFAULT_ETHERTYPE = 16'h88B5;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_SIZE_HI,
        ST_SIZE_LO,
        ST_HDR,
        ST_PAYLOAD,
        ST_WAIT_RST
    } state_e;

    typedef struct packed {
        logic       wr_en;
        logic [7:0] data;
    } tx_beat_t;

    // Byte idx of the header vector, byte 0 being the most significant.
    function automatic logic [7:0] hdr_byte(input logic [HDR_BITS-1:0] hdr, input logic [3:0] idx);
        logic [HDR_BITS-1:0] shifted;
        shifted = hdr << {idx, 3'b000};
        return shifted[HDR_BITS-1 -: 8];
    endfunction

endpackage

// File: rtl/eth_frame_tx_buf.sv
// Simple dual-port payload byte RAM: synchronous write, registered read (1-cycle latency).
module eth_frame_tx_buf #(
    parameter int unsigned DEPTH = 1500,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/eth_frame_tx.sv
// Packetizer: buffers a byte stream and writes size + Ethernet header + payload into the MAC TX FIFO.
module eth_frame_tx
    import eth_frame_tx_pkg::*;
#(
    parameter logic [47:0]  MAC_ADDRESS    = 48'h000102030405,
    parameter logic [47:0]  DEST_MAC       = 48'hFFFFFFFFFFFF,
    parameter logic [15:0]  ETHERTYPE      = DEFAULT_ETHERTYPE,
    parameter int unsigned  MAX_PAYLOAD    = 1500,
    parameter int unsigned  TIMEOUT_CYCLES = 32000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_last_i,
    output logic        in_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_wr_en_o,
    input  logic        tx_full_i,
    input  logic        tx_reset_i,
    output logic        busy_o,
    output logic [15:0] frames_o
);

    localparam int unsigned CW = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int unsigned IW = (CW > 4) ? CW : 4;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CW-1:0]       MAX_CNT  = CW'(MAX_PAYLOAD);
    localparam bit                  TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0]       TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IW-1:0]       HDR_END  = IW'(HDR_LEN - 1);
    localparam logic [HDR_BITS-1:0] HDR_C    = {DEST_MAC, MAC_ADDRESS, ETHERTYPE};

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [IW-1:0] idx_q, idx_d;
    tx_beat_t      tx_q, tx_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic [15:0]   frames_q, frames_d;

    logic          accept_c;
    logic          buf_we_c;
    logic [AW-1:0] rd_addr_c;
    logic [7:0]    rd_data_c;
    logic [15:0]   size_c;

    assign accept_c = in_valid_i & in_ready_q;
    assign buf_we_c = accept_c & ~rst_i;
    assign size_c   = 16'(HDR_LEN) + 16'(count_q);

    eth_frame_tx_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_buf (
        .clk_i     (clk_i),
        .wr_en_i   (buf_we_c),
        .wr_addr_i (AW'(count_q)),
        .wr_data_i (in_data_i),
        .rd_addr_i (rd_addr_c),
        .rd_data_o (rd_data_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tmo_d    = tmo_q;
        idx_d    = idx_q;
        frames_d = frames_q;
        tx_d     = '{wr_en: 1'b0, data: tx_q.data};

        unique case (state_q)
            ST_FILL: begin
                idx_d = '0;
                if (accept_c) begin
                    count_d = count_q + CW'(1);
                    tmo_d   = '0;
                    if (in_last_i || (count_d == MAX_CNT)) begin
                        state_d = ST_SIZE_HI;
                    end
                end else if (count_q != '0) begin
                    tmo_d = tmo_q + TW'(1);
                    if (TMO_EN && (tmo_q == TMO_LAST)) begin
                        state_d = ST_SIZE_HI;
                    end
                end
                if (state_d != ST_FILL) begin
                    tmo_d = '0;
                end
            end
            ST_WAIT_RST: begin
                if (!tx_reset_i && !tx_full_i) begin
                    state_d = ST_SIZE_HI;
                    idx_d   = '0;
                end
            end
            default: begin
                // A FIFO reset abandons the attempt; the buffer is kept for a full resend.
                if (tx_reset_i) begin
                    state_d = ST_WAIT_RST;
                    idx_d   = '0;
                end else if (!tx_full_i) begin
                    tx_d.wr_en = 1'b1;
                    unique case (state_q)
                        ST_SIZE_HI: begin
                            tx_d.data = size_c[15:8];
                            state_d   = ST_SIZE_LO;
                        end
                        ST_SIZE_LO: begin
                            tx_d.data = size_c[7:0];
                            state_d   = ST_HDR;
                            idx_d     = '0;
                        end
                        ST_HDR: begin
                            tx_d.data = hdr_byte(HDR_C, idx_q[3:0]);
                            if (idx_q == HDR_END) begin
                                state_d = ST_PAYLOAD;
                                idx_d   = '0;
                            end else begin
                                idx_d = idx_q + IW'(1);
                            end
                        end
                        ST_PAYLOAD: begin
                            tx_d.data = rd_data_c;
                            if (idx_q == (IW'(count_q) - IW'(1))) begin
                                state_d  = ST_FILL;
                                idx_d    = '0;
                                count_d  = '0;
                                frames_d = frames_q + 16'd1;
                            end else begin
                                idx_d = idx_q + IW'(1);
                            end
                        end
                        default: begin
                            tx_d.wr_en = 1'b0;
                        end
                    endcase
                end
            end
        endcase

        in_ready_d = (state_d == ST_FILL) && (count_d < MAX_CNT);
        busy_d     = (state_d != ST_FILL);
    end

    // Prefetch: RAM address tracks the payload index of the next cycle.
    assign rd_addr_c = (state_d == ST_PAYLOAD) ? AW'(idx_d) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_FILL;
            count_q    <= '0;
            tmo_q      <= '0;
            idx_q      <= '0;
            tx_q       <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            frames_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            frames_q   <= frames_d;
        end
    end

    assign in_ready_o = in_ready_q;
    assign tx_data_o  = tx_q.data;
    assign tx_wr_en_o = tx_q.wr_en;
    assign busy_o     = busy_q;
    assign frames_o   = frames_q;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed scoreboard bench for eth_frame_tx: expected FIFO bytes queued at stimulus time, popped on writes.
module tb_eth_frame_tx;

    localparam int unsigned TMO = 100;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_last_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_wr_en_o;
    logic        tx_full_i = 1'b0;
    logic        tx_reset_i = 1'b0;
    logic        busy_o;
    logic [15:0] frames_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q   [$];
    logic [7:0] frame_q [$];
    logic [7:0] pl_q    [$];
    logic [7:0] hdr_exp [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                 8'h88, 8'hB5};

    eth_frame_tx #(
        .MAC_ADDRESS    (48'h000102030405),
        .DEST_MAC       (48'hFFFFFFFFFFFF),
        .ETHERTYPE      (16'h88B5),
        .MAX_PAYLOAD    (1500),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_last_i  (in_last_i),
        .in_ready_o (in_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_wr_en_o (tx_wr_en_o),
        .tx_full_i  (tx_full_i),
        .tx_reset_i (tx_reset_i),
        .busy_o     (busy_o),
        .frames_o   (frames_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every FIFO write must match the next expected byte.
    always @(negedge clk_i) begin
        logic [7:0] exp_b;
        if (tx_wr_en_o === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL tx_unexpected observed=%0h expected=none", tx_data_o);
            end
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                total++;
                assert (tx_data_o === exp_b) else begin
                    bad++;
                    $error("FAIL tx_data observed=%0h expected=%0h", tx_data_o, exp_b);
                end
            end
        end
    end

    task automatic build_frame(input int n, input logic [7:0] seed);
        logic [15:0] sz;
        frame_q.delete();
        pl_q.delete();
        sz = 16'(14 + n);
        frame_q.push_back(sz[15:8]);
        frame_q.push_back(sz[7:0]);
        for (int i = 0; i < 14; i++) frame_q.push_back(hdr_exp[i]);
        for (int i = 0; i < n; i++) begin
            pl_q.push_back(seed + 8'(i));
            frame_q.push_back(seed + 8'(i));
        end
    endtask

    task automatic expect_bytes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(frame_q[i]);
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic push(input logic [7:0] d, input logic l);
        int n = 0;
        while (!in_ready_o && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 5000) check("ready_timeout", 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = l;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic push_payload(input logic last);
        for (int i = 0; i < pl_q.size(); i++) push(pl_q[i], last && (i == pl_q.size() - 1));
    endtask

    task automatic wait_writes(input int cnt);
        int seen = 0;
        int n = 0;
        while (seen < cnt && n < 4000) begin
            @(negedge clk_i);
            n++;
            if (tx_wr_en_o) seen++;
        end
        check("write_count", 32'(seen), 32'(cnt));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 4000) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int  n;
        int  run;
        logic seen;

        repeat (3) @(negedge clk_i);
        check("rst_ready", 32'(in_ready_o), 32'd1);
        check("rst_wr_en", 32'(tx_wr_en_o), 32'd0);
        check("rst_data", 32'(tx_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_frames", 32'(frames_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Three-byte record, one contiguous 19-byte frame.
        build_frame(3, 8'hA1);
        expect_bytes(frame_q.size());
        push_payload(1'b1);
        n = 0;
        while (!tx_wr_en_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        run = 0;
        while (tx_wr_en_o && run < 100) begin
            run++;
            @(negedge clk_i);
        end
        check("short_contiguous", 32'(run), 32'd19);
        wait_done("short");
        check("short_frames", 32'(frames_o), 32'd1);

        // Full buffer forces a flush and blocks input until the frame is out.
        build_frame(1500, 8'h10);
        expect_bytes(frame_q.size());
        push_payload(1'b0);
        check("max_ready_low", 32'(in_ready_o), 32'd0);
        check("max_busy", 32'(busy_o), 32'd1);
        seen = 1'b0;
        n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 4000) begin
            if (busy_o && in_ready_o) seen = 1'b1;
            @(negedge clk_i);
            n++;
        end
        check("max_ready_held", 32'(seen), 32'd0);
        wait_done("max");
        check("max_frames", 32'(frames_o), 32'd2);
        build_frame(1, 8'hC3);
        expect_bytes(frame_q.size());
        push_payload(1'b1);
        wait_done("after_max");
        check("after_max_frames", 32'(frames_o), 32'd3);

        // Single byte, no last: flush after exactly TMO idle cycles.
        build_frame(1, 8'h77);
        expect_bytes(frame_q.size());
        push_payload(1'b0);
        n = 0;
        while (!busy_o && n < int'(TMO) + 20) begin
            @(negedge clk_i);
            n++;
        end
        check("timeout_delay", 32'(n), 32'(TMO));
        wait_done("timeout");
        check("timeout_frames", 32'(frames_o), 32'd4);
        seen = 1'b0;
        repeat (3 * TMO) begin
            @(negedge clk_i);
            if (busy_o) seen = 1'b1;
        end
        check("empty_no_flush", 32'(seen), 32'd0);
        check("empty_frames", 32'(frames_o), 32'd4);

        // FIFO full for 5 cycles mid-payload: writes stall, byte order preserved.
        build_frame(8, 8'h30);
        expect_bytes(frame_q.size());
        push_payload(1'b1);
        wait_writes(18);
        tx_full_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            check("full_no_write", 32'(tx_wr_en_o), 32'd0);
        end
        tx_full_i = 1'b0;
        wait_done("full");
        check("full_frames", 32'(frames_o), 32'd5);

        // FIFO reset after 10 bytes: abort, then resend the whole frame.
        build_frame(20, 8'h55);
        expect_bytes(10);
        expect_bytes(frame_q.size());
        push_payload(1'b1);
        wait_writes(10);
        tx_reset_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            check("txrst_no_write", 32'(tx_wr_en_o), 32'd0);
        end
        tx_reset_i = 1'b0;
        wait_done("txrst");
        check("txrst_frames", 32'(frames_o), 32'd6);

        // Synchronous reset mid-payload discards the frame.
        build_frame(30, 8'h90);
        expect_bytes(25);
        push_payload(1'b1);
        wait_writes(25);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_ready", 32'(in_ready_o), 32'd1);
        check("midrst_wr_en", 32'(tx_wr_en_o), 32'd0);
        check("midrst_data", 32'(tx_data_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_frames", 32'(frames_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        build_frame(5, 8'hE0);
        expect_bytes(frame_q.size());
        push_payload(1'b1);
        wait_done("post_rst");
        check("post_rst_frames", 32'(frames_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
